// File: rtl/ext_pkg.sv
// Shared control encodings for the immediate/load extension pipe.
package ext_pkg;
    localparam int CTRL_W = 3;

    typedef enum logic [CTRL_W-1:0] {
        CTRL_ZEXT = 3'b000,
        CTRL_SEXT = 3'b001,
        CTRL_LUI  = 3'b010,
        CTRL_BOFF = 3'b011,
        CTRL_LB   = 3'b100,
        CTRL_LBU  = 3'b101,
        CTRL_LH   = 3'b110,
        CTRL_LHU  = 3'b111
    } ext_ctrl_e;
endpackage

// File: rtl/ext_comb.sv
// Combinational immediate extension and load byte/halfword selection.
// Load modes (100-111) exist only when EXT_LOAD_EN is defined; otherwise they yield zero.
module ext_comb
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_addr_lo,
    output logic [DATA_W-1:0] o_data,
    output logic              o_misalign
);
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;

    assign w_zext = {{(DATA_W-IMM_W){1'b0}}, i_imm};
    assign w_sext = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};

`ifdef EXT_LOAD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_word[16 +: 16] : i_word[0 +: 16];
`else
    logic w_unused_load;
    assign w_unused_load = ^{i_word, i_addr_lo};
`endif

    always_comb begin
        o_data     = '0;
        o_misalign = 1'b0;
        case (i_ctrl)
            CTRL_ZEXT: o_data = w_zext;
            CTRL_SEXT: o_data = w_sext;
            CTRL_LUI:  o_data = {i_imm, {(DATA_W-IMM_W){1'b0}}};
            CTRL_BOFF: o_data = w_sext << 2;
`ifdef EXT_LOAD_EN
            CTRL_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            CTRL_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
            // Odd-address halfword: flag it and return zero rather than a torn value.
            CTRL_LH:   if (i_addr_lo[0]) o_misalign = 1'b1;
                       else o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            CTRL_LHU:  if (i_addr_lo[0]) o_misalign = 1'b1;
                       else o_data = {{(DATA_W-16){1'b0}}, w_half};
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/ext_pipe.sv
// Single-stage extension pipe: main output register plus one-entry skid buffer.
// Load modes are built only with macro EXT_LOAD_EN defined (requires DATA_W == 32).
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_ctrl,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_word,
    input  logic [1:0]        in_addr_lo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign
);
    logic [DATA_W-1:0] w_data;
    logic              w_misalign;
    logic              w_accept;
    logic              w_main_free;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_mis;
    logic              r_skid_full;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_mis;

    ext_comb #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_comb (
        .i_ctrl     (in_ctrl),
        .i_imm      (in_imm),
        .i_word     (in_word),
        .i_addr_lo  (in_addr_lo),
        .o_data     (w_data),
        .o_misalign (w_misalign)
    );

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready    = ~r_skid_full;
    assign w_accept    = in_valid & in_ready;
    assign w_main_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mis   <= 1'b0;
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
            r_skid_mis  <= 1'b0;
        end else if (w_main_free) begin
            // Skid drains first to keep order; a full skid blocks new accepts.
            if (r_skid_full) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_skid_data;
                r_out_mis   <= r_skid_mis;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_mis   <= w_misalign;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_full <= 1'b1;
            r_skid_data <= w_data;
            r_skid_mis  <= w_misalign;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_misalign = r_out_mis;
endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: streaming vector table plus stall/skid and reset sequences.
module tb_ext_pipe;
`ifdef EXT_LOAD_EN
    localparam bit LD = 1'b1;
`else
    localparam bit LD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ctrl;
    logic [15:0] in_imm;
    logic [31:0] in_word;
    logic [1:0]  in_addr_lo;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_misalign;

    int total = 0;
    int bad   = 0;

    ext_pipe #(.IMM_W(16), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_imm       (in_imm),
        .in_word      (in_word),
        .in_addr_lo   (in_addr_lo),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_misalign (out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [15:0] imm;
        logic [31:0] word;
        logic [1:0]  addr;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [15:0] imm,
                         input logic [31:0] w, input logic [1:0] a);
        in_valid = v; in_ctrl = c; in_imm = imm; in_word = w; in_addr_lo = a;
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic [15:0] imm, input logic [31:0] w,
                                input logic [1:0] a, input logic [31:0] d, input logic m);
        vec_t v;
        v.ctrl = c; v.imm = imm; v.word = w; v.addr = a; v.exp_data = d; v.exp_mis = m;
        return v;
    endfunction

    initial begin
        // Load results collapse to zero when the load modes are not built.
        vecs[0]  = mk(3'b000, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0);
        vecs[1]  = mk(3'b001, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
        vecs[2]  = mk(3'b010, 16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0);
        vecs[3]  = mk(3'b011, 16'h8001, 32'h0, 2'd0, 32'hFFFE0004, 1'b0);
        vecs[4]  = mk(3'b001, 16'h7FFF, 32'h0, 2'd0, 32'h00007FFF, 1'b0);
        vecs[5]  = mk(3'b011, 16'h0003, 32'h0, 2'd0, 32'h0000000C, 1'b0);
        vecs[6]  = mk(3'b100, 16'h0, 32'h80FF7F01, 2'd1, LD ? 32'h0000007F : 32'h0, 1'b0);
        vecs[7]  = mk(3'b101, 16'h0, 32'h80FF7F01, 2'd3, LD ? 32'h00000080 : 32'h0, 1'b0);
        vecs[8]  = mk(3'b100, 16'h0, 32'h80FF7F01, 2'd2, LD ? 32'hFFFFFFFF : 32'h0, 1'b0);
        vecs[9]  = mk(3'b110, 16'h0, 32'h80FF7F01, 2'd2, LD ? 32'hFFFF80FF : 32'h0, 1'b0);
        vecs[10] = mk(3'b111, 16'h0, 32'h80FF7F01, 2'd1, 32'h0, LD);
        vecs[11] = mk(3'b101, 16'h0, 32'h80FF7F01, 2'd0, LD ? 32'h00000001 : 32'h0, 1'b0);
        vecs[12] = mk(3'b111, 16'h0, 32'h80FF7F01, 2'd2, LD ? 32'h000080FF : 32'h0, 1'b0);
        vecs[13] = mk(3'b110, 16'h0, 32'h80FF7F01, 2'd0, LD ? 32'h00007F01 : 32'h0, 1'b0);

        reset = 1'b1; out_ready = 1'b1;
        drive(1'b1, 3'b001, 16'hFFFF, 32'h0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_misalign", {31'b0, out_misalign}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 3'b000, 16'h0, 32'h0, 2'd0);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Streaming: one request per cycle, result the cycle after accept.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].ctrl, vecs[i].imm, vecs[i].word, vecs[i].addr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_mis", i), {31'b0, out_misalign}, {31'b0, vecs[i].exp_mis});
            chk($sformatf("vec%0d_ready", i), {31'b0, in_ready}, 32'd1);
        end
        @(negedge clk);
        drive(1'b0, 3'b000, 16'h0, 32'h0, 2'd0);
        @(posedge clk); #1;
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Stall: A held, B in skid, C refused until room opens; order A,B,C.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 16'h00A1, 32'h0, 2'd0);
        @(posedge clk); #1;
        chk("stall_A_data", out_data, 32'h000000A1);
        chk("stall_A_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b1, 3'b001, 16'h80B2, 32'h0, 2'd0);
        @(posedge clk); #1;
        chk("stall_B_held", out_data, 32'h000000A1);
        chk("stall_B_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        drive(1'b1, 3'b010, 16'h00C3, 32'h0, 2'd0);
        @(posedge clk); #1;
        chk("stall_C_held", out_data, 32'h000000A1);
        chk("stall_C_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_C_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel_B_data", out_data, 32'hFFFF80B2);
        chk("rel_B_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        @(posedge clk); #1;
        chk("rel_C_data", out_data, 32'h00C30000);
        chk("rel_C_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        drive(1'b0, 3'b000, 16'h0, 32'h0, 2'd0);
        @(posedge clk); #1;
        chk("rel_end_valid", {31'b0, out_valid}, 32'd0);

        // Reset while both entries are held: nothing stale may reappear.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 16'h0011, 32'h0, 2'd0);
        @(negedge clk);
        drive(1'b1, 3'b000, 16'h0022, 32'h0, 2'd0);
        @(negedge clk);
        #1;
        chk("pre_rst_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        drive(1'b1, 3'b000, 16'h0033, 32'h0, 2'd0);
        @(posedge clk); #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_data", out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'b000, 16'h0, 32'h0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_valid%0d", k), {31'b0, out_valid}, 32'd0);
        end

        // Load-mode request in either build: valid after one cycle.
        @(negedge clk);
        drive(1'b1, 3'b100, 16'h0, 32'h000000F0, 2'd0);
        @(posedge clk); #1;
        chk("ld100_valid", {31'b0, out_valid}, 32'd1);
        chk("ld100_data", out_data, LD ? 32'hFFFFFFF0 : 32'h0);
        @(negedge clk);
        drive(1'b0, 3'b000, 16'h0, 32'h0, 2'd0);
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter IMM_W, default 16, immediate field width.
REQ-002 SHALL have parameter DATA_W, default 32, result width; DATA_W >= IMM_W+2 is required.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream request valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port in_ctrl, input, 3, mode select (REQ-014).
REQ-008 SHALL have port in_imm, input, IMM_W, immediate operand.
REQ-009 SHALL have port in_word, input, DATA_W, raw load word for load modes.
REQ-010 SHALL have port in_addr_lo, input, 2, byte offset of the load address.
REQ-011 SHALL have port out_valid, input-side counterpart output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have ports out_data (output, DATA_W, extended result) and out_misalign (output, 1, halfword load at odd address).

Function
REQ-014 SHALL decode in_ctrl: 000 zero-ext; 001 sign-ext; 010 load-upper {imm, zeros}; 011 branch offset = sign-ext(imm) shifted left 2; 100 lb; 101 lbu; 110 lh; 111 lhu.
REQ-015 SHALL select byte in_word[8*a+7:8*a] for lb/lbu with a = in_addr_lo, and halfword in_word[16*h+15:16*h] for lh/lhu with h = in_addr_lo[1], then sign- or zero-extend it to DATA_W.
REQ-016 SHALL, for lh/lhu with in_addr_lo[0]=1, produce out_data=0 and out_misalign=1; out_misalign SHALL be 0 for every other mode.
REQ-017 SHALL accept a request on a cycle where in_valid && in_ready, and present its result with out_valid=1 on the next cycle (latency 1).
REQ-018 SHALL hold results in a main output register plus a one-entry skid register; in_ready SHALL equal NOT skid_full, so it is a registered value with no combinational path from out_ready.
REQ-019 SHALL, when out_valid && !out_ready, hold out_data/out_misalign stable, and SHALL place one further accepted request in the skid.
REQ-020 SHALL, on out_valid && out_ready, move the skid entry to the main register if the skid is full, else load the newly accepted request, else clear out_valid.
REQ-021 SHALL sustain one result per cycle while out_ready stays high, and SHALL preserve request order in all cases.
REQ-022 SHALL handle simultaneous accept and output fire with the skid empty by replacing the main register, with no bubble.
REQ-023 SHALL treat in_valid as ignored when in_ready=0; no data SHALL be lost or duplicated.

Reset
REQ-024 SHALL, on a reset cycle, clear out_valid, out_data, out_misalign and skid_full to 0, and discard any request presented in that cycle.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset; reset mid-stall SHALL discard both held entries.

Configuration
REQ-026 SHALL compile the load modes (100-111, REQ-015/016) only when macro EXT_LOAD_EN is defined; DATA_W SHALL be 32 in that case.
REQ-027 SHALL, without EXT_LOAD_EN, return out_data=0 and out_misalign=0 for in_ctrl 100-111, with handshake timing unchanged.

Structure
REQ-028 SHALL take the in_ctrl encodings and mode constants from shared package ext_pkg.
REQ-029 SHALL place the pure combinational extension/selection in sub-module ext_comb, with ext_pipe holding the registers and handshake.

Verification
REQ-030 Zero/sign/upper/branch with imm=16'h8001, out_ready=1 -> 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, one per cycle at 1-cycle latency.
REQ-031 lb/lbu on in_word=32'h80FF7F01 at addr 1, 3 and 2 -> 32'h0000007F, 32'h00000080 and 32'hFFFFFFFF respectively; lh at addr 2 -> 32'hFFFF80FF.
REQ-032 lhu at addr 1 -> out_data=0, out_misalign=1; next request lbu at addr 0 -> misalign back to 0.
REQ-033 Back-to-back requests A, B, C with out_ready=0 from cycle 1 -> A held, B in skid, in_ready=0, C not accepted; release out_ready -> A, B, C emerge in order.
REQ-034 Reset asserted while skid full -> next cycle out_valid=0, in_ready=1, no stale result ever emitted.
REQ-035 Build without EXT_LOAD_EN, in_ctrl=100 -> out_data=0, out_valid after 1 cycle.
